// File: rtl/anneal_sched_if.sv
// Control/status bundle between the annealing schedule sequencer and its run controller.
// The master drives the launch/abort request and schedule config; the slave reports the schedule.
interface anneal_sched_if #(
    parameter int CYC_W = 16,
    parameter int Q_W   = 8
);
    logic             start;
    logic             abort;
    logic [CYC_W-1:0] cyc_per_stage;
    logic [Q_W-1:0]   q_init;
    logic [Q_W-1:0]   q_step;
    logic [Q_W-1:0]   noise_init;
    logic [Q_W-1:0]   noise_step;
    logic [3:0]       state_signal;
    logic [Q_W-1:0]   q_val;
    logic [Q_W-1:0]   noise_amp;
    logic             stage_tick;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, cyc_per_stage, q_init, q_step, noise_init, noise_step,
        input  state_signal, q_val, noise_amp, stage_tick, busy, done
    );

    modport slave (
        input  start, abort, cyc_per_stage, q_init, q_step, noise_init, noise_step,
        output state_signal, q_val, noise_amp, stage_tick, busy, done
    );
endinterface

// File: rtl/anneal_sched.sv
// Annealing schedule sequencer: steps a stage index 0..STAGES, holding each stage for N cycles,
// while ramping the coupling Q up and decaying the noise amplitude, both saturating.
module anneal_sched #(
    parameter int STAGES = 10,
    parameter int CYC_W  = 16,
    parameter int Q_W    = 8
) (
    input  logic         clk,
    input  logic         rst_sys,
    anneal_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_STAGE = 4'(STAGES);

    state_t           state, state_nxt;
    logic [3:0]       stage, stage_nxt;
    logic [CYC_W-1:0] cnt, cnt_nxt;
    logic [Q_W-1:0]   q_reg, q_nxt;
    logic [Q_W-1:0]   noise_reg, noise_nxt;
    logic             tick_reg, tick_nxt;
    logic             busy_reg, done_reg;
    logic             ld;

    // Latched schedule config; only meaningful once a start has been accepted.
    logic [CYC_W-1:0] last_cnt;
    logic [Q_W-1:0]   q_step_lat;
    logic [Q_W-1:0]   noise_step_lat;

    function automatic logic [Q_W-1:0] sat_add(input logic [Q_W-1:0] a, input logic [Q_W-1:0] b);
        logic [Q_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[Q_W] ? {Q_W{1'b1}} : sum[Q_W-1:0];
    endfunction

    function automatic logic [Q_W-1:0] sat_sub(input logic [Q_W-1:0] a, input logic [Q_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    function automatic logic [CYC_W-1:0] last_of(input logic [CYC_W-1:0] n);
        return (n == '0) ? '0 : (n - CYC_W'(1));
    endfunction

    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        cnt_nxt   = cnt;
        q_nxt     = q_reg;
        noise_nxt = noise_reg;
        tick_nxt  = 1'b0;
        ld        = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                    stage_nxt = '0;
                    cnt_nxt   = '0;
                    q_nxt     = '0;
                    noise_nxt = '0;
                end else if (bus.start) begin
                    ld        = 1'b1;
                    state_nxt = RUN;
                    stage_nxt = '0;
                    cnt_nxt   = '0;
                    q_nxt     = bus.q_init;
                    noise_nxt = bus.noise_init;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                    stage_nxt = '0;
                    cnt_nxt   = '0;
                    q_nxt     = '0;
                    noise_nxt = '0;
                end else if (cnt == last_cnt) begin
                    cnt_nxt   = '0;
                    stage_nxt = stage + 4'd1;
                    q_nxt     = sat_add(q_reg, q_step_lat);
                    noise_nxt = sat_sub(noise_reg, noise_step_lat);
                    tick_nxt  = 1'b1;
                    if (stage_nxt == LAST_STAGE) begin
                        state_nxt = DONE;
                    end
                end else begin
                    cnt_nxt = cnt + CYC_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                stage_nxt = '0;
                cnt_nxt   = '0;
                q_nxt     = '0;
                noise_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_sys) begin
        if (!rst_sys) begin
            state     <= IDLE;
            stage     <= '0;
            cnt       <= '0;
            q_reg     <= '0;
            noise_reg <= '0;
            tick_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state     <= state_nxt;
            stage     <= stage_nxt;
            cnt       <= cnt_nxt;
            q_reg     <= q_nxt;
            noise_reg <= noise_nxt;
            tick_reg  <= tick_nxt;
            busy_reg  <= (state_nxt == RUN);
            done_reg  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (ld) begin
            last_cnt       <= last_of(bus.cyc_per_stage);
            q_step_lat     <= bus.q_step;
            noise_step_lat <= bus.noise_step;
        end
    end

    assign bus.state_signal = stage;
    assign bus.q_val        = q_reg;
    assign bus.noise_amp    = noise_reg;
    assign bus.stage_tick   = tick_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
endmodule

// File: tb/tb_anneal_sched.sv
// Scoreboard bench for anneal_sched: launches push expected stage ticks, a negedge monitor pops
// and compares them, and the stimulus process checks launch, final, abort and reset states.
module tb_anneal_sched;
    logic clk;
    logic rst_sys;
    int   cyc;
    int   checks;
    int   errors;
    int   busy_cnt;
    int   tick_cnt;
    int   done_cyc;

    typedef struct {
        int cyc;
        int stage;
        int q;
        int noise;
        bit last;
    } exp_t;

    exp_t exp_q[$];

    anneal_sched_if #(.CYC_W(16), .Q_W(8)) bus();

    anneal_sched #(.STAGES(10), .CYC_W(16), .Q_W(8)) dut (
        .clk     (clk),
        .rst_sys (rst_sys),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: every tick must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy) busy_cnt++;
        if (bus.stage_tick) begin
            tick_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick stage=%0d required=no tick", bus.state_signal);
            end else begin
                e = exp_q.pop_front();
                chk("tick_cycle", cyc, e.cyc);
                chk("tick_stage", int'(bus.state_signal), e.stage);
                chk("tick_q", int'(bus.q_val), e.q);
                chk("tick_noise", int'(bus.noise_amp), e.noise);
                chk("tick_done", int'(bus.done), int'(e.last));
                chk("tick_busy", int'(bus.busy), int'(!e.last));
                if (e.last) done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_run(input int p, input int n, input int qi, input int qs,
                            input int ni, input int ns);
        int q;
        int nz;
        int ne;
        exp_t e;
        q  = qi;
        nz = ni;
        ne = (n == 0) ? 1 : n;
        for (int k = 1; k <= 10; k++) begin
            q  = (q + qs > 255) ? 255 : q + qs;
            nz = (nz > ns) ? nz - ns : 0;
            e.cyc   = p + k * ne;
            e.stage = k;
            e.q     = q;
            e.noise = nz;
            e.last  = (k == 10);
            exp_q.push_back(e);
        end
    endtask

    task automatic launch(input int n, input int qi, input int qs, input int ni, input int ns,
                          output int p);
        bus.cyc_per_stage = 16'(n);
        bus.q_init        = 8'(qi);
        bus.q_step        = 8'(qs);
        bus.noise_init    = 8'(ni);
        bus.noise_step    = 8'(ns);
        bus.start         = 1'b1;
        p        = cyc + 1;
        busy_cnt = 0;
        tick_cnt = 0;
        done_cyc = -1;
        push_run(p, n, qi, qs, ni, ns);
        step();
        bus.start = 1'b0;
        chk("launch_busy", int'(bus.busy), 1);
        chk("launch_done", int'(bus.done), 0);
        chk("launch_stage", int'(bus.state_signal), 0);
        chk("launch_q", int'(bus.q_val), qi);
        chk("launch_noise", int'(bus.noise_amp), ni);
    endtask

    task automatic wait_done(input int limit);
        int i;
        i = 0;
        while (!bus.done && i < limit) begin
            step();
            i++;
        end
        chk("done_within_budget", int'(bus.done), 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_stage(input int s, input int limit);
        int i;
        i = 0;
        while (int'(bus.state_signal) != s && i < limit) begin
            step();
            i++;
        end
        chk("reached_stage", int'(bus.state_signal), s);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_stage"}, int'(bus.state_signal), 0);
        chk({tag, "_q"}, int'(bus.q_val), 0);
        chk({tag, "_noise"}, int'(bus.noise_amp), 0);
        chk({tag, "_tick"}, int'(bus.stage_tick), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
    endtask

    initial begin
        int p;
        checks = 0;
        errors = 0;
        busy_cnt = 0;
        tick_cnt = 0;
        done_cyc = -1;
        rst_sys = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cyc_per_stage = '0;
        bus.q_init = '0;
        bus.q_step = '0;
        bus.noise_init = '0;
        bus.noise_step = '0;
        repeat (3) step();
        chk_idle("reset");
        rst_sys = 1'b1;
        step();

        // Nominal run with a start pulse and a q_step change mid-run, both of which must be ignored.
        launch(3, 10, 5, 100, 8, p);
        repeat (4) step();
        bus.start  = 1'b1;
        bus.q_init = 8'd0;
        step();
        bus.start  = 1'b0;
        bus.q_step = 8'd77;
        wait_done(40);
        chk("nominal_done_cycle", done_cyc, p + 30);
        chk("nominal_final_q", int'(bus.q_val), 60);
        chk("nominal_final_noise", int'(bus.noise_amp), 20);
        chk("nominal_final_stage", int'(bus.state_signal), 10);
        chk("nominal_busy_cycles", busy_cnt, 30);
        chk("nominal_ticks", tick_cnt, 10);
        repeat (3) step();
        chk("done_hold_stage", int'(bus.state_signal), 10);
        chk("done_hold_q", int'(bus.q_val), 60);
        chk("done_hold_level", int'(bus.done), 1);

        // Restart from DONE repeats the same schedule.
        launch(3, 10, 5, 100, 8, p);
        wait_done(40);
        chk("restart_done_cycle", done_cyc, p + 30);
        chk("restart_final_q", int'(bus.q_val), 60);
        chk("restart_final_noise", int'(bus.noise_amp), 20);

        // Saturation of both ramps.
        launch(2, 250, 3, 5, 2, p);
        step();
        step();
        chk("sat_first_q", int'(bus.q_val), 253);
        chk("sat_first_noise", int'(bus.noise_amp), 3);
        wait_done(30);
        chk("sat_final_q", int'(bus.q_val), 255);
        chk("sat_final_noise", int'(bus.noise_amp), 0);

        // Zero cycle count behaves as one cycle per stage.
        launch(0, 1, 1, 50, 1, p);
        wait_done(15);
        chk("zero_busy_cycles", busy_cnt, 10);
        chk("zero_ticks", tick_cnt, 10);
        chk("zero_done_cycle", done_cyc, p + 10);
        chk("zero_final_q", int'(bus.q_val), 11);

        // Abort at stage 4 with start also high: back to IDLE, no relaunch.
        launch(3, 20, 4, 60, 3, p);
        wait_stage(4, 20);
        exp_q.delete();
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        chk_idle("abort");
        bus.abort = 1'b0;
        bus.start = 1'b0;
        repeat (5) step();
        chk_idle("post_abort");

        // Async reset between edges at stage 6.
        launch(3, 20, 4, 60, 3, p);
        wait_stage(6, 25);
        exp_q.delete();
        rst_sys = 1'b0;
        #1;
        chk_idle("async_reset");
        step();
        rst_sys = 1'b1;
        repeat (5) step();
        chk_idle("post_reset");

        // First start after reset release is accepted normally.
        launch(1, 0, 100, 255, 100, p);
        wait_done(15);
        chk("post_reset_final_q", int'(bus.q_val), 255);
        chk("post_reset_final_noise", int'(bus.noise_amp), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached at t=%0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/anneal_sched.md
# anneal_sched

Annealing schedule sequencer for the SSQA core. It steps a 4-bit stage index from 0 to STAGES and holds each stage for a programmable number of clock cycles. At each stage it ramps the replica-coupling magnitude Q up and decays the noise amplitude, both with saturation. Its `state_signal` output drives the run/finish controller directly, so the controller sees value 10 exactly when the schedule completes.

## Interface
- `STAGES`, 10, final stage index; 1..15; the schedule ends when `state_signal` reaches this value.
- `CYC_W`, 16, width of the cycles-per-stage count.
- `Q_W`, 8, width of the Q and noise values; saturation ceiling is 2^Q_W-1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_sys`  in  1  single clock domain; reset is asynchronous and active-low.
- `start`  in  1  launch request; accepted in IDLE and DONE, ignored in RUN.
- `abort`  in  1  returns the block to IDLE from any state; takes priority over `start`.
- `cyc_per_stage`  in  CYC_W  cycles spent in each stage; sampled on accepted `start`; 0 is treated as 1.
- `q_init`, `q_step`  in  Q_W each  initial Q and per-stage Q increment; sampled on `start`.
- `noise_init`, `noise_step`  in  Q_W each  initial noise and per-stage decrement; sampled on `start`.
- `state_signal`  out  4  current stage index.
- `q_val`  out  Q_W  current coupling magnitude.
- `noise_amp`  out  Q_W  current noise amplitude.
- `stage_tick`  out  1  one-cycle pulse, coincident with each new stage value.
- `busy`  out  1  high in RUN.
- `done`  out  1  level; high in DONE.

## Operation
- FSM states:
  - IDLE -> RUN on `start & ~abort`.
  - RUN -> DONE when the stage advance produces `STAGES`.
  - DONE -> RUN on `start & ~abort`.
  - Any state -> IDLE on `abort`.
  - Unused encodings -> IDLE.
- Accepted `start`:
  - Latch all config inputs, with `cyc_per_stage` of 0 mapped to 1.
  - Clear the cycle counter and set stage to 0.
  - Load `q_val` with `q_init` and `noise_amp` with `noise_init`.
- Config inputs are ignored outside an accepted `start`; changes during RUN have no effect.
- RUN, each cycle: the cycle counter increments. When the counter equals latched N-1, one stage advance happens:
  - counter resets to 0 and stage increments by 1;
  - `q_val` becomes min(q+q_step, 2^Q_W-1), computed at Q_W+1 bits;
  - `noise_amp` becomes noise-step if noise > step, else 0;
  - `stage_tick` is 1 for that cycle.
- DONE: `state_signal` holds `STAGES`, and `q_val`/`noise_amp` hold their final values. No ticks occur.
- Abort: all outputs go to their reset values on the next edge. Latched config is don't-care.
- Reset values (asynchronous): `state_signal`=0, `q_val`=0, `noise_amp`=0, `stage_tick`=0, `busy`=0, `done`=0; FSM in IDLE.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` sampled at edge T gives `busy`=1, `state_signal`=0 and `q_val`=`q_init` at T+1.
- Stage k (k≥1) appears at T+1+k·N, together with `stage_tick`=1 in that same cycle.
- Stage `STAGES` appears at T+1+STAGES·N. At that same edge `done`=1 and `busy`=0; total busy time is STAGES·N cycles.
- `start` in DONE at edge T: `done`=0, `busy`=1 and `state_signal`=0 at T+1.
- `abort` at edge T: IDLE with zeroed outputs at T+1. `start` asserted in the same cycle is ignored.
- Deasserting `rst_sys` takes effect synchronously; the first `start` is accepted on the first edge with `rst_sys`=1.

## Test plan
- Nominal run: N=3, `q_init`=10, `q_step`=5, `noise_init`=100, `noise_step`=8, `start` at T.
  - `state_signal` steps 0..10, changing every 3 cycles, with 10 ticks.
  - `q_val`=60 and `noise_amp`=20 at the end.
  - `done`=1 at T+31.
- Saturation: `q_init`=250, `q_step`=3 -> `q_val` 253, 255, 255, ...; `noise_init`=5, `noise_step`=2 -> `noise_amp` 3, 1, 0, 0, ...
- Zero cycle count: `cyc_per_stage`=0 -> the stage advances every cycle; `busy` is high for exactly 10 cycles; `stage_tick` is high for all 10.
- Abort: `abort` asserted while `state_signal`=4, with `start` also high -> next cycle IDLE with all outputs 0, and no relaunch.
- Restart and ignored inputs:
  - `start` pulsed in RUN -> no effect.
  - Change `q_step` mid-run -> ramp is unchanged.
  - `start` in DONE -> `done`=0 and `state_signal`=0 next cycle, and the run repeats identically.
- Async reset: drive `rst_sys` low between clock edges at stage 6 -> all outputs 0 immediately, without waiting for a clock edge. After release, the block stays IDLE until `start`.
